// File: rtl/iob_uart_poll_bridge.sv
// Native-bus master that polls an iob_uart register port and moves bytes between
// the UART and a pair of first-word-fall-through byte FIFOs (RX out, TX in).

module iob_uart_poll_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      level_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so occupancy never exceeds DEPTH and its MSB flags full.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = level_o[AW];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

module iob_uart_poll_bridge #(
  parameter int                DATA_W          = 32,
  parameter int                ADDR_W          = 3,
  parameter logic [ADDR_W-1:0] RXREADY_ADDR    = 3'd5,
  parameter logic [ADDR_W-1:0] TXREADY_ADDR    = 3'd4,
  parameter logic [ADDR_W-1:0] RXDATA_ADDR     = 3'd7,
  parameter logic [ADDR_W-1:0] TXDATA_ADDR     = 3'd6,
  parameter int                FIFO_DEPTH_LOG2 = 4,
  parameter int                POLL_GAP        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     uart_valid,
  output logic [ADDR_W-1:0]        uart_addr,
  output logic [DATA_W-1:0]        uart_wdata,
  output logic [DATA_W/8-1:0]      uart_wstrb,
  input  logic [DATA_W-1:0]        uart_rdata,
  input  logic                     uart_ready,
  output logic                     rx_valid,
  output logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     tx_valid,
  input  logic [7:0]               tx_data,
  output logic                     tx_ready,
  output logic [FIFO_DEPTH_LOG2:0] rx_level,
  output logic [FIFO_DEPTH_LOG2:0] tx_level
);
  localparam int STRB_W = DATA_W / 8;
  localparam int GAP_W  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(POLL_GAP);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [STRB_W-1:0] STRB_B0  = STRB_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_RX, S_RD_RX, S_CHK_TX, S_WR_TX, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               moved_q, moved_d;

  logic       ack;
  logic       rx_push, rx_empty, rx_full;
  logic       tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       unused_rdata_hi;

  assign ack             = valid_q & uart_ready;
  assign unused_rdata_hi = ^uart_rdata[DATA_W-1:8];

  iob_uart_poll_bridge_fifo #(.WIDTH(8), .AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push_i(rx_push), .data_i(uart_rdata[7:0]),
    .pop_i(rx_ready), .data_o(rx_data),
    .level_o(rx_level), .empty_o(rx_empty), .full_o(rx_full)
  );

  iob_uart_poll_bridge_fifo #(.WIDTH(8), .AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push_i(tx_valid), .data_i(tx_data),
    .pop_i(tx_pop), .data_o(tx_head),
    .level_o(tx_level), .empty_o(tx_empty), .full_o(tx_full)
  );

  assign rx_valid   = ~rx_empty;
  assign tx_ready   = ~tx_full;
  assign uart_valid = valid_q;
  assign uart_addr  = addr_q;
  assign uart_wdata = wdata_q;
  assign uart_wstrb = wstrb_q;

  // Bus states issue their request while valid is low and advance on the ack; with en low
  // they park instead of issuing, so an in-flight transaction always completes first.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    gap_d   = gap_q;
    moved_d = moved_q;
    rx_push = 1'b0;
    tx_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        moved_d = 1'b0;
        if (gap_q != '0)  gap_d   = gap_q - GAP_ONE;
        else if (en)      state_d = S_CHK_RX;
      end
      S_CHK_RX: begin
        if (!valid_q) begin
          if (!en) state_d = S_IDLE;
          else begin
            valid_d = 1'b1;
            addr_d  = RXREADY_ADDR;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end else if (ack) begin
          valid_d = 1'b0;
          state_d = (uart_rdata[0] && !rx_full) ? S_RD_RX : S_CHK_TX;
        end
      end
      S_RD_RX: begin
        if (!valid_q) begin
          if (!en) state_d = S_IDLE;
          else begin
            valid_d = 1'b1;
            addr_d  = RXDATA_ADDR;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end else if (ack) begin
          valid_d = 1'b0;
          rx_push = 1'b1;
          moved_d = 1'b1;
          state_d = S_CHK_TX;
        end
      end
      S_CHK_TX: begin
        if (!valid_q) begin
          if (!en)          state_d = S_IDLE;
          else if (tx_empty) state_d = S_DONE;
          else begin
            valid_d = 1'b1;
            addr_d  = TXREADY_ADDR;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end else if (ack) begin
          valid_d = 1'b0;
          state_d = uart_rdata[0] ? S_WR_TX : S_DONE;
        end
      end
      S_WR_TX: begin
        if (!valid_q) begin
          if (!en) state_d = S_IDLE;
          else begin
            valid_d      = 1'b1;
            addr_d       = TXDATA_ADDR;
            wdata_d      = '0;
            wdata_d[7:0] = tx_head;
            wstrb_d      = STRB_B0;
          end
        end else if (ack) begin
          valid_d = 1'b0;
          wstrb_d = '0;
          tx_pop  = 1'b1;
          moved_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        moved_d = 1'b0;
        if (en && (moved_q || POLL_GAP == 0)) state_d = S_CHK_RX;
        else begin
          gap_d   = GAP_LOAD;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      gap_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      gap_q   <= gap_d;
      moved_q <= moved_d;
    end
  end
endmodule

// File: tb/tb_iob_uart_poll_bridge.sv
// Bench for iob_uart_poll_bridge: a behavioural UART register model answers the bus,
// and scoreboards compare byte order, FIFO levels and bus-request stability.

module tb_iob_uart_poll_bridge;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int LOG2   = 4;
  localparam int DEPTH  = 16;
  localparam logic [2:0] A_TXRDY = 3'd4, A_RXRDY = 3'd5, A_TXD = 3'd6, A_RXD = 3'd7;

  logic              clk;
  logic              rst, en;
  logic              uart_valid;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_wstrb;
  logic [DATA_W-1:0] uart_rdata = '0;
  logic              uart_ready = 1'b0;
  logic              rx_valid, rx_ready;
  logic [7:0]        rx_data;
  logic              tx_valid, tx_ready;
  logic [7:0]        tx_data;
  logic [LOG2:0]     rx_level, tx_level;

  iob_uart_poll_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .RXREADY_ADDR(A_RXRDY), .TXREADY_ADDR(A_TXRDY),
    .RXDATA_ADDR(A_RXD), .TXDATA_ADDR(A_TXD),
    .FIFO_DEPTH_LOG2(LOG2), .POLL_GAP(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .uart_valid(uart_valid), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_level(rx_level), .tx_level(tx_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // UART model and scoreboards
  logic [7:0] uart_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] popped[$];
  logic [7:0] tx_written[$];
  logic       model_txready = 1'b0;
  int         rxd_reads = 0, txd_writes = 0, rises_total = 0, cyc = 0;
  int         model_rx_cnt = 0, model_tx_cnt = 0;
  int         rise_cyc[$];
  int         stall_max = 0, wait_cnt = 0;
  bit         hold_rd = 1'b0, rand_rx = 1'b0;
  bit         hold_chk = 1'b0, prev_valid = 1'b0;
  logic [38:0] saved_req = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-port responder: random stall, one-cycle ack, read data from the model.
  always @(negedge clk) begin
    if (rst) begin
      uart_ready = 1'b0;
      wait_cnt   = 0;
    end else if (uart_ready) begin
      uart_ready = 1'b0;
      uart_rdata = '0;
      wait_cnt   = int'($urandom_range(stall_max, 0));
    end else if (uart_valid && !(hold_rd && uart_addr == A_RXD)) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        uart_ready = 1'b1;
        case (uart_addr)
          A_RXRDY: uart_rdata = {31'b0, uart_q.size() != 0};
          A_RXD:   uart_rdata = (uart_q.size() != 0) ? {24'b0, uart_q[0]} : '0;
          A_TXRDY: uart_rdata = {31'b0, model_txready};
          default: uart_rdata = '0;
        endcase
      end
    end
  end

  // Commit monitor: bus completions, stream pops/pushes, request stability.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_rx_cnt = 0;
      model_tx_cnt = 0;
      exp_tx.delete();
      exp_rx = uart_q;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", uart_valid, 1);
        chk("hold_req", {uart_addr, uart_wdata, uart_wstrb}, saved_req);
      end
      if (uart_valid && !prev_valid && uart_addr == A_RXRDY) begin
        rise_cyc.push_back(cyc);
        rises_total++;
      end
      if (uart_valid && uart_ready) begin
        if (uart_addr == A_RXD) begin
          rxd_reads++;
          chk("rxd_not_full", rx_level < DEPTH, 1);
          chk("rxd_uart_has_byte", uart_q.size() != 0, 1);
          if (uart_q.size() != 0) void'(uart_q.pop_front());
          model_rx_cnt++;
        end else if (uart_addr == A_TXD) begin
          txd_writes++;
          chk("txd_wstrb", uart_wstrb, 4'b0001);
          chk("txd_uart_ready", model_txready, 1);
          chk("txd_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) begin
            chk("txd_wdata", uart_wdata, {24'b0, exp_tx[0]});
            void'(exp_tx.pop_front());
          end
          tx_written.push_back(uart_wdata[7:0]);
          model_tx_cnt--;
        end
      end
      if (rx_valid && rx_ready) begin
        popped.push_back(rx_data);
        chk("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) chk("rx_data_order", rx_data, exp_rx.pop_front());
        model_rx_cnt--;
      end
      if (tx_valid && tx_ready) begin
        exp_tx.push_back(tx_data);
        model_tx_cnt++;
      end
    end
    prev_valid = uart_valid;
    hold_chk   = uart_valid && !uart_ready && !rst;
    saved_req  = {uart_addr, uart_wdata, uart_wstrb};
  end

  // Occupancy and handshake flags must match the counted traffic every cycle.
  always @(negedge clk) begin
    chk("rx_level", rx_level, model_rx_cnt);
    chk("tx_level", tx_level, model_tx_cnt);
    chk("rx_valid", rx_valid, model_rx_cnt != 0);
    chk("tx_ready", tx_ready, model_tx_cnt < DEPTH);
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rx) rx_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic add_rx(input logic [7:0] b);
    uart_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 500) begin tick(); n++; end
    chk("push_tx_timeout", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    int base, basew, n, r;
    rst = 1'b1; en = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", uart_valid, 0);
    chk("rst_addr", uart_addr, 0);
    chk("rst_wdata", uart_wdata, 0);
    chk("rst_wstrb", uart_wstrb, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_level", rx_level, 0);
    rst = 1'b0;

    // T1: reset while an RXDATA read is outstanding
    add_rx(8'h5A);
    hold_rd = 1'b1;
    en = 1'b1;
    n = 0;
    while (!(uart_valid && uart_addr == A_RXD) && n < 200) begin @(negedge clk); n++; end
    chk("t1_reach_rd_rx", uart_valid && uart_addr == A_RXD, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_valid_drop", uart_valid, 0);
    chk("t1_rx_level", rx_level, 0);
    chk("t1_tx_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_rd = 1'b0;
    chk("t1_no_commit", rxd_reads, 0);
    chk("t1_byte_kept", uart_q.size(), 1);
    n = 0;
    while (!uart_valid && n < 50) begin @(negedge clk); n++; end
    chk("t1_first_addr", uart_addr, A_RXRDY);
    rx_ready = 1'b1;
    n = 0;
    while (popped.size() < 1 && n < 300) begin @(negedge clk); n++; end
    chk("t1_popped", popped.size(), 1);

    // T2: short RX stream
    base = rxd_reads;
    add_rx(8'h41); add_rx(8'h42); add_rx(8'h43);
    n = 0;
    while (popped.size() < 4 && n < 500) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    chk("t2_reads", rxd_reads - base, 3);
    chk("t2_count", popped.size(), 4);
    if (popped.size() >= 4) begin
      chk("t2_b0", popped[1], 8'h41);
      chk("t2_b1", popped[2], 8'h42);
      chk("t2_b2", popped[3], 8'h43);
    end

    // T3: RX FIFO fills; extra bytes stay in the UART
    rx_ready = 1'b0;
    base = rxd_reads;
    for (int i = 0; i < 20; i++) add_rx(8'(8'h60 + i));
    n = 0;
    while (rx_level != DEPTH && n < 2000) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    chk("t3_level_full", rx_level, DEPTH);
    chk("t3_reads16", rxd_reads - base, 16);
    chk("t3_uart_left", uart_q.size(), 4);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (100) @(negedge clk);
    chk("t3_reads17", rxd_reads - base, 17);
    chk("t3_level_refill", rx_level, DEPTH);
    rx_ready = 1'b1;
    n = 0;
    while ((uart_q.size() != 0 || rx_level != 0) && n < 3000) begin @(negedge clk); n++; end
    chk("t3_drained", uart_q.size() + int'(rx_level), 0);

    // T4: TX bytes wait for TXREADY
    model_txready = 1'b0;
    basew = txd_writes;
    tx_written.delete();
    push_tx(8'h0A);
    push_tx(8'h55);
    repeat (30) @(negedge clk);
    chk("t4_no_write_busy", txd_writes - basew, 0);
    chk("t4_tx_level", tx_level, 2);
    model_txready = 1'b1;
    n = 0;
    while (tx_level != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("t4_writes", txd_writes - basew, 2);
    if (tx_written.size() >= 2) begin
      chk("t4_w0", tx_written[0], 8'h0A);
      chk("t4_w1", tx_written[1], 8'h55);
    end

    // T5: random bus stalls with mixed traffic
    stall_max = 7;
    rand_rx = 1'b1;
    base = popped.size();
    basew = txd_writes;
    for (int i = 0; i < 12; i++) add_rx(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      push_tx(8'($urandom));
      repeat (int'($urandom_range(3, 0))) tick();
    end
    n = 0;
    while ((uart_q.size() != 0 || rx_level != 0 || tx_level != 0) && n < 8000) begin tick(); n++; end
    rand_rx = 1'b0;
    rx_ready = 1'b1;
    chk("t5_rx_count", popped.size() - base, 12);
    chk("t5_tx_count", txd_writes - basew, 8);
    stall_max = 0;

    // T6: idle polling spacing, then park with en low
    repeat (30) @(negedge clk);
    rise_cyc.delete();
    repeat (80) @(negedge clk);
    chk("t6_rounds", rise_cyc.size() >= 3, 1);
    for (int i = 1; i < rise_cyc.size(); i++)
      chk("t6_gap", (rise_cyc[i] - rise_cyc[i-1]) >= 10, 1);
    en = 1'b0;
    @(negedge clk);
    r = rises_total;
    repeat (60) @(negedge clk);
    chk("t6_parked", rises_total - r, 0);
    chk("t6_valid_low", uart_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
